pixel_lane_capture: RTL and testbench
=====================================

Name: pixel_lane_capture

Overview:
Sink at the far end of the 8-lane pixel output bus (out1..out8) of the image-processing top level. Packs the 8 parallel 8-bit pixel lanes into 64-bit words and writes them into an internal frame buffer of IMG_W x IMG_H pixels. Tracks row/column position, accumulates a checksum and flags frame completion. A registered read port returns the captured frame for verification or host readback.

Parameters:
IMG_W, 16, pixels per row; must be a multiple of 8.
IMG_H, 2, rows per frame.
WORDS, IMG_W*IMG_H/8, derived; 64-bit words per frame.
ADDR_W, clog2(WORDS) (min 1), derived; word address width.

Ports:
CLK  in  1  single clock; all logic on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
start  in  1  arms or restarts a frame capture.
in_valid  in  1  lanes in1..in8 carry a valid 8-pixel beat.
in1..in8  in  8 each  pixel lanes; in1 is the leftmost (lowest column) pixel.
busy  out  1  high in CAPTURE.
done  out  1  high in DONE.
drop_err  out  1  sticky; a beat arrived outside CAPTURE.
row_idx  out  16  row of the next write.
col_idx  out  16  pixel column of the next write.
checksum  out  16  running sum of all captured pixels, mod 2^16.
rd_en  in  1  read request.
rd_addr  in  ADDR_W  word address to read.
rd_data  out  64  read word; in1 is at bits [7:0], in8 at bits [63:56].
rd_valid  out  1  rd_data valid.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE. busy, done, drop_err, row_idx, col_idx, checksum, rd_data and rd_valid all go to 0. Write address goes to 0. Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE to CAPTURE on start.
  - CAPTURE to DONE on the accepted beat at write address WORDS-1.
  - DONE to CAPTURE on start.
  - start in CAPTURE restarts the capture and stays in CAPTURE.
- Any start, in any state, clears all of the following on the next edge: write address, row_idx, col_idx, checksum, done and drop_err. The in_valid beat in the start cycle is ignored and does not set drop_err. Capture begins with the next cycle.
- CAPTURE, in_valid=1, start=0:
  - Write {in8,...,in1} to mem[wr_addr].
  - Increment wr_addr.
  - Add the zero-extended 11-bit sum of the 8 lanes to checksum.
  - col_idx advances by 8. On reaching IMG_W, col_idx returns to 0 and row_idx increments.
- in_valid=0 leaves all state unchanged; gaps are unlimited.
- Last beat: done=1 and busy=0 on the following cycle. row_idx wraps to 0 and col_idx to 0. checksum holds its final value until the next start.
- in_valid=1 in IDLE or DONE (without start): no write, no checksum change, drop_err set to 1 and held until start or reset.
- Read port:
  - 1-cycle latency: rd_en at edge N gives rd_data and rd_valid at edge N+1.
  - rd_valid=0 when rd_en was 0; rd_data then holds its last value.
  - Reads are allowed in every state.
  - Reading and writing the same address in the same cycle returns the old data (read-before-write).
  - rd_addr values >= WORDS return an undefined value; they must not corrupt state.
- Reset asserted mid-capture aborts the frame: state IDLE, outputs as at reset. A new start is required.

Decomposition:
- Shared package pixel_cap_pkg holds:
  - LANES=8 and PIX_W=8
  - the state enum {IDLE, CAPTURE, DONE}
  - the checksum width constant (16).
- One sub-module, pixel_word_ram: simple dual-port RAM, WORDS x 64, with a synchronous write port and a registered read port with read-before-write semantics. FSM, counters and checksum stay in pixel_lane_capture.

Test Plan:
1. Full frame, defaults (WORDS=4). Stimulus: start, then 4 consecutive beats with in_k = w*8+(k-1) for w=0..3. Required: done=1 and busy=0 one cycle after the 4th beat; checksum=496 (0x01F0); rd_addr=2 gives rd_data=0x17161514_13121110 one cycle after rd_en.
2. Gapped input: same 4 beats with 3 idle cycles between each. Required: identical checksum and buffer contents. Before beat 2: row_idx=0, col_idx=8. Before beat 3: row_idx=1, col_idx=0.
3. Stray beat: in_valid=1 with all lanes 0xFF while IDLE. Required: drop_err=1, checksum=0, mem unchanged. Then start: drop_err=0 next cycle.
4. Restart: start, 2 beats of all-0x01, start, then 4 beats of all-0x02. Required: checksum=64 (0x0040); done after the 4th beat of the second sequence; mem[0]=0x0202020202020202.
5. Reset mid-capture: RST_N=0 after 2 beats. Required: busy=0, done=0, checksum=0, rd_valid=0 immediately. After release and start, a full frame completes normally.
6. Collision: read rd_addr=1 in the same cycle beat 1 (all 0xAA) is written, where mem[1] previously held 0x55 in all bytes. Required: rd_data=0x5555555555555555. A re-read on the next cycle returns 0xAAAAAAAAAAAAAAAA.

Source files
------------

// File: rtl/pixel_cap_pkg.sv
// Shared constants and state type for the pixel lane capture sink.
// Latency: n/a (package only).
// Backpressure: n/a.
package pixel_cap_pkg;

    localparam int LANES  = 8;
    localparam int PIX_W  = 8;
    localparam int WORD_W = LANES * PIX_W;
    localparam int CSUM_W = 16;
    localparam int SUM_W  = PIX_W + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pixel_word_ram.sv
// Simple dual-port word RAM: synchronous write, registered read-before-write read.
// Latency: read data and valid one cycle after rd_en.
// Backpressure: none; every read and write is accepted.
module pixel_word_ram #(
    parameter int WORDS  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] mem [WORDS];

    // Storage is deliberately not reset; a frame must be captured before it is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_lane_capture.sv
// Packs 8 pixel lanes into 64-bit words, stores one frame, tracks position and checksum.
// Latency: state/counters update on the beat edge; read port returns data one cycle after rd_en.
// Backpressure: none; beats outside CAPTURE are dropped and flagged in drop_err.
module pixel_lane_capture
    import pixel_cap_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 2,
    localparam int WORDS  = IMG_W * IMG_H / LANES,
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in1,
    input  logic [7:0]        in2,
    input  logic [7:0]        in3,
    input  logic [7:0]        in4,
    input  logic [7:0]        in5,
    input  logic [7:0]        in6,
    input  logic [7:0]        in7,
    input  logic [7:0]        in8,
    output logic              busy,
    output logic              done,
    output logic              drop_err,
    output logic [15:0]       row_idx,
    output logic [15:0]       col_idx,
    output logic [15:0]       checksum,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [63:0]       rd_data,
    output logic              rd_valid
);

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] lane_word;
    logic [SUM_W-1:0]  lane_sum;
    logic              wr_en;
    logic              last_beat;

    assign lane_word = {in8, in7, in6, in5, in4, in3, in2, in1};
    assign wr_en     = (state == CAPTURE) && in_valid && !start;
    assign last_beat = (wr_addr == ADDR_W'(WORDS - 1));

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++)
            lane_sum = lane_sum + SUM_W'(lane_word[k*PIX_W +: PIX_W]);
    end

    // start has priority over any beat in the same cycle: that beat is discarded silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            drop_err <= 1'b0;
            wr_addr  <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            checksum <= '0;
        end else if (start) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            done     <= 1'b0;
            drop_err <= 1'b0;
            wr_addr  <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            checksum <= '0;
        end else if (in_valid) begin
            if (state == CAPTURE) begin
                checksum <= checksum + CSUM_W'(lane_sum);
                if (last_beat) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    wr_addr <= '0;
                    row_idx <= '0;
                    col_idx <= '0;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                    if (col_idx + 16'(LANES) == 16'(IMG_W)) begin
                        col_idx <= '0;
                        row_idx <= row_idx + 16'd1;
                    end else begin
                        col_idx <= col_idx + 16'(LANES);
                    end
                end
            end else begin
                drop_err <= 1'b1;
            end
        end
    end

    pixel_word_ram #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (lane_word),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_pixel_lane_capture.sv
// Directed and randomized bench for pixel_lane_capture against a frame-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_pixel_lane_capture;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 2;
    localparam int WORDS  = IMG_W * IMG_H / 8;
    localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [63:0]       drv_word = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              busy, done, drop_err, rd_valid;
    logic [15:0]       row_idx, col_idx, checksum;
    logic [63:0]       rd_data;

    int checks = 0;
    int failures = 0;

    // Reference model: frame-level view (beats taken, pixel sum, stored words).
    logic [63:0] m_mem [WORDS];
    int          m_state;   // 0 idle, 1 capturing, 2 frame complete
    int          m_n;
    int          m_csum;
    bit          m_drop;
    logic [63:0] m_rd;
    bit          m_rdv;

    always #5 clk = ~clk;

    pixel_lane_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in1      (drv_word[7:0]),
        .in2      (drv_word[15:8]),
        .in3      (drv_word[23:16]),
        .in4      (drv_word[31:24]),
        .in5      (drv_word[39:32]),
        .in6      (drv_word[47:40]),
        .in7      (drv_word[55:48]),
        .in8      (drv_word[63:56]),
        .busy     (busy),
        .done     (done),
        .drop_err (drop_err),
        .row_idx  (row_idx),
        .col_idx  (col_idx),
        .checksum (checksum),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bytesum(input logic [63:0] w);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(w[k*8 +: 8]);
        return s;
    endfunction

    function automatic logic [63:0] ramp(input int base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(base + k);
        return r;
    endfunction

    function automatic logic [63:0] fill(input logic [7:0] b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = b;
        return r;
    endfunction

    task automatic check_all(input string tag);
        int p;
        p = (m_n * 8) % (IMG_W * IMG_H);
        chk({tag, ".busy"},     64'(busy),     64'(m_state == 1));
        chk({tag, ".done"},     64'(done),     64'(m_state == 2));
        chk({tag, ".drop_err"}, 64'(drop_err), 64'(m_drop));
        chk({tag, ".row_idx"},  64'(row_idx),  64'(p / IMG_W));
        chk({tag, ".col_idx"},  64'(col_idx),  64'(p % IMG_W));
        chk({tag, ".checksum"}, 64'(checksum), 64'(m_csum));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rdv));
        if (!$isunknown(m_rd)) chk({tag, ".rd_data"}, rd_data, m_rd);
    endtask

    // One clock cycle: update the model, drive the DUT, then check after the edge.
    task automatic cyc(input string tag, input bit st, input bit v, input logic [63:0] w,
                       input bit re, input int ra);
        if (re) m_rd = m_mem[ra];
        m_rdv = re;
        if (st) begin
            m_state = 1; m_n = 0; m_csum = 0; m_drop = 0;
        end else if (v) begin
            if (m_state == 1) begin
                m_mem[m_n] = w;
                m_csum = (m_csum + bytesum(w)) % 65536;
                m_n++;
                if (m_n == WORDS) begin
                    m_state = 2;
                    m_n = 0;
                end
            end else begin
                m_drop = 1;
            end
        end
        start = st; in_valid = v; drv_word = w; rd_en = re; rd_addr = ra[ADDR_W-1:0];
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_state = 0; m_n = 0; m_csum = 0; m_drop = 0; m_rd = '0; m_rdv = 0;
        check_all(tag);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) m_mem[i] = 'x;
        #1;
        do_reset("reset");

        // 1: full frame, back-to-back beats
        cyc("t1_start", 1, 0, '0, 0, 0);
        for (int w = 0; w < 4; w++) cyc("t1_beat", 0, 1, ramp(w * 8), 0, 0);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_csum", 64'(checksum), 64'h01F0);
        cyc("t1_rd", 0, 0, '0, 1, 2);
        chk("t1_rd2", rd_data, 64'h1716151413121110);

        // 2: gapped beats
        cyc("t2_start", 1, 0, '0, 0, 0);
        for (int w = 0; w < 4; w++) begin
            if (w == 1) begin
                chk("t2_row_b2", 64'(row_idx), 64'd0);
                chk("t2_col_b2", 64'(col_idx), 64'd8);
            end
            if (w == 2) begin
                chk("t2_row_b3", 64'(row_idx), 64'd1);
                chk("t2_col_b3", 64'(col_idx), 64'd0);
            end
            cyc("t2_beat", 0, 1, ramp(w * 8), 0, 0);
            if (w < 3) idle("t2_gap", 3);
        end
        chk("t2_csum", 64'(checksum), 64'h01F0);
        for (int a = 0; a < 4; a++) cyc("t2_rd", 0, 0, '0, 1, a);
        chk("t2_rd3", rd_data, 64'h1F1E1D1C1B1A1918);

        // 3: stray beat while idle
        do_reset("t3_reset");
        cyc("t3_stray", 0, 1, fill(8'hFF), 0, 0);
        chk("t3_drop", 64'(drop_err), 64'd1);
        chk("t3_csum", 64'(checksum), 64'd0);
        cyc("t3_rd0", 0, 0, '0, 1, 0);
        chk("t3_mem0", rd_data, 64'h0706050403020100);
        cyc("t3_start", 1, 1, fill(8'hFF), 0, 0);
        chk("t3_drop_clr", 64'(drop_err), 64'd0);

        // 4: restart mid-frame
        cyc("t4_start", 1, 0, '0, 0, 0);
        for (int i = 0; i < 2; i++) cyc("t4_b1", 0, 1, fill(8'h01), 0, 0);
        cyc("t4_restart", 1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("t4_b2", 0, 1, fill(8'h02), 0, 0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_csum", 64'(checksum), 64'h0040);
        cyc("t4_rd0", 0, 0, '0, 1, 0);
        chk("t4_mem0", rd_data, 64'h0202020202020202);

        // 5: reset mid-capture
        cyc("t5_start", 1, 0, '0, 0, 0);
        cyc("t5_b", 0, 1, fill(8'h33), 0, 0);
        cyc("t5_b", 0, 1, fill(8'h44), 1, 3);
        do_reset("t5_reset");
        chk("t5_rdv", 64'(rd_valid), 64'd0);
        cyc("t5_start2", 1, 0, '0, 0, 0);
        for (int w = 0; w < 4; w++) cyc("t5_beat", 0, 1, ramp(100 + w * 8), 0, 0);
        chk("t5_done", 64'(done), 64'd1);

        // 6: read-before-write collision
        cyc("t6_start", 1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("t6_fill", 0, 1, fill(8'h55), 0, 0);
        cyc("t6_start2", 1, 0, '0, 0, 0);
        cyc("t6_b0", 0, 1, fill(8'h11), 0, 0);
        cyc("t6_coll", 0, 1, fill(8'hAA), 1, 1);
        chk("t6_old", rd_data, 64'h5555555555555555);
        cyc("t6_reread", 0, 0, '0, 1, 1);
        chk("t6_new", rd_data, 64'hAAAAAAAAAAAAAAAA);

        // randomized traffic: starts, gaps, strays, reads
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom % 16) == 0, ($urandom % 3) != 0,
                {$urandom, $urandom}, ($urandom % 2) == 1, int'($urandom % WORDS));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
